// File: rtl/nibble_serial_add_seq_pkg.sv
// Shared definitions for the nibble-serial addition sequencer: nibble width,
// sequencer state encoding and the nibble-count helper.
package nibble_serial_add_seq_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  function automatic int nibbles_of(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/nibble_serial_add_seq.sv
// Drives one external 4-bit full adder a nibble per clock (LSB first), builds the
// WIDTH-bit sum, carry-out and signed overflow, and pulses DONE on completion.
module nibble_serial_add_seq
  import nibble_serial_add_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic             OVF,
  output logic [3:0]       ADD_A,
  output logic [3:0]       ADD_B,
  output logic             ADD_CIN,
  input  logic [3:0]       ADD_F,
  input  logic             ADD_COUT
);

  localparam int NIBBLES = nibbles_of(WIDTH);
  localparam int IDX_W   = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic               c_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   work_q;
  logic [WIDTH-1:0]   work_nxt;

  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  assign BUSY = (state != ST_IDLE);
  assign DONE = (state == ST_DONE);

  // Adder side: present the current nibble pair only while running
  always_comb begin
    ADD_A    = '0;
    ADD_B    = '0;
    ADD_CIN  = 1'b0;
    work_nxt = work_q;
    if (state == ST_RUN) begin
      ADD_A   = a_q[idx*NIBBLE_W +: NIBBLE_W];
      ADD_B   = b_q[idx*NIBBLE_W +: NIBBLE_W];
      ADD_CIN = c_q;
    end
    work_nxt[idx*NIBBLE_W +: NIBBLE_W] = ADD_F;
  end

  // Sequencer; results are published only on the final capture
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
      idx   <= '0;
      c_q   <= 1'b0;
      SUM   <= '0;
      COUT  <= 1'b0;
      OVF   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (START) begin
            a_q   <= A;
            b_q   <= B;
            c_q   <= CIN;
            idx   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          work_q <= work_nxt;
          c_q    <= ADD_COUT;
          idx    <= idx + 1'b1;
          if (idx == IDX_LAST) begin
            state <= ST_DONE;
            SUM   <= work_nxt;
            COUT  <= ADD_COUT;
            OVF   <= signed_ovf(a_q[WIDTH-1], b_q[WIDTH-1], work_nxt[WIDTH-1]);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_seq.sv
// Bench for nibble_serial_add_seq (WIDTH=16) with a behavioural 4-bit adder attached,
// an arithmetic reference model checked every cycle, and directed literal checks.
module tb_nibble_serial_add_seq;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          START;
  logic [W-1:0]  A, B;
  logic          CIN;
  logic          BUSY, DONE, COUT, OVF;
  logic [W-1:0]  SUM;
  logic [3:0]    ADD_A, ADD_B, ADD_F;
  logic          ADD_CIN, ADD_COUT;

  nibble_serial_add_seq #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B), .CIN(CIN),
    .BUSY(BUSY), .DONE(DONE), .SUM(SUM), .COUT(COUT), .OVF(OVF),
    .ADD_A(ADD_A), .ADD_B(ADD_B), .ADD_CIN(ADD_CIN),
    .ADD_F(ADD_F), .ADD_COUT(ADD_COUT)
  );

  // External 4-bit full adder
  assign {ADD_COUT, ADD_F} = 5'(ADD_A) + 5'(ADD_B) + 5'(ADD_CIN);

  always #5 CLK = ~CLK;

  int nchk = 0;
  int nfail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: operation phase counter plus plain-integer arithmetic
  int          cyc = 0;
  bit          armed = 0;
  bit          m_active = 0;
  int          m_p = 0;
  logic [31:0] ma, mb;
  logic        mc;
  logic [31:0] esum = 0;
  logic        ecout = 0, eovf = 0;

  function automatic logic carry_into(input int p);
    logic [31:0] mask;
    if (p == 0) return mc;
    mask = (32'd1 << (4 * p)) - 32'd1;
    return 1'(((ma & mask) + (mb & mask) + 32'(mc)) >> (4 * p));
  endfunction

  always @(posedge CLK) begin
    logic [31:0] full;
    cyc++;
    if (RST) begin
      armed = 1; m_active = 0; m_p = 0;
      esum = 0; ecout = 0; eovf = 0;
    end else if (m_active) begin
      if (m_p == NIB) m_active = 0;
      else begin
        m_p++;
        if (m_p == NIB) begin
          full  = ma + mb + 32'(mc);
          esum  = full & 32'hFFFF;
          ecout = full[16];
          eovf  = (ma[15] == mb[15]) && (esum[15] != ma[15]);
        end
      end
    end else if (START) begin
      m_active = 1; m_p = 0;
      ma = 32'(A); mb = 32'(B); mc = CIN;
    end
  end

  always @(negedge CLK) begin
    bit run;
    if (armed) begin
      run = m_active && (m_p < NIB);
      chk("busy", 32'(BUSY), 32'(m_active));
      chk("done", 32'(DONE), 32'(m_active && m_p == NIB));
      chk("sum", 32'(SUM), esum);
      chk("cout", 32'(COUT), 32'(ecout));
      chk("ovf", 32'(OVF), 32'(eovf));
      chk("add_a", 32'(ADD_A), run ? ((ma >> (4 * m_p)) & 32'hF) : 32'd0);
      chk("add_b", 32'(ADD_B), run ? ((mb >> (4 * m_p)) & 32'hF) : 32'd0);
      chk("add_cin", 32'(ADD_CIN), run ? 32'(carry_into(m_p)) : 32'd0);
    end
  end

  // Record the adder-side nibble sequence of the current operation
  logic [15:0] seq_a, seq_b;
  logic [3:0]  seq_c;
  int          k = 0;
  always @(negedge CLK) begin
    if (BUSY === 1'b1 && DONE === 1'b0 && k < NIB) begin
      seq_a[4*k +: 4] = ADD_A;
      seq_b[4*k +: 4] = ADD_B;
      seq_c[k]        = ADD_CIN;
      k++;
    end else if (BUSY !== 1'b1) begin
      k = 0;
    end
  end

  int s_edge;

  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic c);
    @(negedge CLK);
    START = 1'b1; A = a; B = b; CIN = c;
    @(negedge CLK);
    START = 1'b0; A = '0; B = '0; CIN = 1'b0;
    s_edge = cyc;
  endtask

  task automatic finish_op(input string name, input logic [15:0] es, input logic ec,
                           input logic eo, input logic [15:0] sa, input logic [15:0] sb,
                           input logic [3:0] sc);
    bit seen = 0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge CLK);
      if (DONE === 1'b1) seen = 1;
    end
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
    chk({name, "_latency"}, 32'(cyc - s_edge), 32'(NIB));
    chk({name, "_sum"}, 32'(SUM), 32'(es));
    chk({name, "_cout"}, 32'(COUT), 32'(ec));
    chk({name, "_ovf"}, 32'(OVF), 32'(eo));
    chk({name, "_seq_a"}, 32'(seq_a), 32'(sa));
    chk({name, "_seq_b"}, 32'(seq_b), 32'(sb));
    chk({name, "_seq_cin"}, 32'(seq_c), 32'(sc));
    @(negedge CLK);
    chk({name, "_done_pulse"}, 32'(DONE), 32'd0);
  endtask

  initial begin
    int dcyc[$];
    RST = 1'b1; START = 1'b0; A = '0; B = '0; CIN = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    chk("reset_busy", 32'(BUSY), 32'd0);
    chk("reset_sum", 32'(SUM), 32'd0);

    start_op(16'h0001, 16'h000A, 1'b0);
    finish_op("s1", 16'h000B, 1'b0, 1'b0, 16'h0001, 16'h000A, 4'b0000);
    start_op(16'h0001, 16'h000A, 1'b1);
    finish_op("s2", 16'h000C, 1'b0, 1'b0, 16'h0001, 16'h000A, 4'b0001);
    start_op(16'hFFFF, 16'h0001, 1'b0);
    finish_op("s3", 16'h0000, 1'b1, 1'b0, 16'hFFFF, 16'h0001, 4'b1110);
    start_op(16'h7FFF, 16'h0001, 1'b0);
    finish_op("s4a", 16'h8000, 1'b0, 1'b1, 16'h7FFF, 16'h0001, 4'b1110);
    start_op(16'h8000, 16'h8000, 1'b0);
    finish_op("s4b", 16'h0000, 1'b1, 1'b1, 16'h8000, 16'h8000, 4'b0000);

    // A second request arriving mid-run must be dropped
    start_op(16'h1234, 16'h1111, 1'b0);
    START = 1'b1; A = 16'hFFFF; B = 16'hFFFF; CIN = 1'b1;
    @(negedge CLK);
    START = 1'b0; A = '0; B = '0; CIN = 1'b0;
    finish_op("s5", 16'h2345, 1'b0, 1'b0, 16'h1234, 16'h1111, 4'b0000);

    // START held high: one operation every NIB+2 cycles
    @(negedge CLK);
    START = 1'b1; A = 16'h0003; B = 16'h0004;
    for (int t = 0; t < 20; t++) begin
      @(negedge CLK);
      if (DONE === 1'b1) dcyc.push_back(cyc);
    end
    START = 1'b0; A = '0; B = '0;
    chk("b2b_pulses", 32'(dcyc.size() >= 3), 32'd1);
    for (int i = 1; i < dcyc.size(); i++)
      chk("b2b_spacing", 32'(dcyc[i] - dcyc[i-1]), 32'(NIB + 2));
    chk("b2b_sum", 32'(SUM), 32'h0007);
    repeat (8) @(negedge CLK);

    // Reset after the second nibble capture abandons the operation
    start_op(16'h1234, 16'h1111, 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("s6_busy", 32'(BUSY), 32'd0);
    chk("s6_done", 32'(DONE), 32'd0);
    chk("s6_sum", 32'(SUM), 32'd0);
    chk("s6_add", {ADD_A, ADD_B, 24'(ADD_CIN)}, 32'd0);
    for (int t = 0; t < 8; t++) begin
      @(negedge CLK);
      chk("s6_no_done", 32'(DONE), 32'd0);
    end
    start_op(16'h0001, 16'h000A, 1'b0);
    finish_op("s6_fresh", 16'h000B, 1'b0, 1'b0, 16'h0001, 16'h000A, 4'b0000);

    repeat (2) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
